// File: rtl/ddr_cmd_dispatch_arb.sv
// Drains write/read request FIFOs into the DDR2 controller app interface, splitting wide
// writes into beats and reassembling read returns tagged with their original address.
module ddr_cmd_dispatch_arb #(
  parameter int ADDR_W          = 27,
  parameter int APP_DATA_W      = 64,
  parameter int USER_DATA_W     = 128,
  parameter int ARB_MODE        = 2,
  parameter int BURST_MAX       = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                has_wr,
  input  logic [ADDR_W-1:0]                   wr_adx_in,
  input  logic [USER_DATA_W-1:0]              wr_data_in,
  output logic                                get_wr,
  input  logic                                has_rd_req,
  input  logic [ADDR_W-1:0]                   rd_adx_in,
  output logic                                get_rd_req,
  output logic [ADDR_W-1:0]                   app_addr,
  output logic [2:0]                          app_cmd,
  output logic                                app_en,
  input  logic                                app_rdy,
  output logic [APP_DATA_W-1:0]               app_wdf_data,
  output logic                                app_wdf_wren,
  output logic                                app_wdf_end,
  input  logic                                app_wdf_rdy,
  input  logic [APP_DATA_W-1:0]               app_rd_data,
  input  logic                                app_rd_data_valid,
  output logic [USER_DATA_W-1:0]              ret_data,
  output logic [ADDR_W-1:0]                   ret_adx,
  output logic                                ret_valid,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding
);

  localparam int BEATS = USER_DATA_W / APP_DATA_W;
  localparam int OW    = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW    = $clog2(MAX_OUTSTANDING);
  localparam int BW    = $clog2(BURST_MAX + 1);
  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR_DATA = 2'd1;
  localparam logic [1:0] WR_CMD  = 2'd2;
  localparam logic [1:0] RD_CMD  = 2'd3;

  logic [1:0]             state;
  logic [2:0]             wbeat;
  logic [2:0]             rbeat;
  logic [BW-1:0]          burst_cnt;
  logic                   last_wr;
  logic [ADDR_W-1:0]      tag_mem [MAX_OUTSTANDING];
  logic [PW-1:0]          tag_wp;
  logic [PW-1:0]          tag_rp;
  logic [USER_DATA_W-1:0] asm_q;
  logic [USER_DATA_W-1:0] asm_next;

  logic wr_elig, rd_elig, same_elig, other_elig;
  logic keep_same, pick_same, pick_other;
  logic grant_wr, grant_rd;
  logic rd_accept, beat_ok, ret_done;

  assign wr_elig    = has_wr;
  assign rd_elig    = has_rd_req && (outstanding < OW'(MAX_OUTSTANDING));
  assign same_elig  = last_wr ? wr_elig : rd_elig;
  assign other_elig = last_wr ? rd_elig : wr_elig;

  // Mode 2: a burst (burst_cnt != 0) may continue up to BURST_MAX, or longer if the other side is idle
  always_comb begin
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    keep_same  = 1'b0;
    pick_same  = 1'b0;
    pick_other = 1'b0;
    if (state == IDLE) begin
      if (ARB_MODE == 0) begin
        grant_wr = wr_elig;
        grant_rd = !wr_elig && rd_elig;
      end else if (ARB_MODE == 1) begin
        grant_rd = rd_elig;
        grant_wr = !rd_elig && wr_elig;
      end else begin
        keep_same  = same_elig && (burst_cnt != '0) &&
                     ((burst_cnt < BW'(BURST_MAX)) || !other_elig);
        pick_other = !keep_same && other_elig;
        pick_same  = !pick_other && same_elig;
        grant_wr   = last_wr ? pick_same  : pick_other;
        grant_rd   = last_wr ? pick_other : pick_same;
      end
    end
  end

  assign rd_accept = (state == RD_CMD) && app_rdy;
  assign beat_ok   = app_rd_data_valid && (outstanding != '0);
  assign ret_done  = beat_ok && (rbeat == LAST_BEAT);

  assign get_wr       = (state == WR_CMD) && app_rdy;
  assign get_rd_req   = rd_accept;
  assign app_en       = (state == WR_CMD) || (state == RD_CMD);
  assign app_cmd      = (state == RD_CMD) ? 3'b001 : 3'b000;
  assign app_addr     = (state == WR_CMD) ? wr_adx_in :
                        (state == RD_CMD) ? rd_adx_in : '0;
  assign app_wdf_wren = (state == WR_DATA);
  assign app_wdf_end  = app_wdf_wren && (wbeat == LAST_BEAT);
  assign app_wdf_data = app_wdf_wren ? wr_data_in[wbeat*APP_DATA_W +: APP_DATA_W] : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      wbeat     <= '0;
      burst_cnt <= '0;
      last_wr   <= 1'b0;
    end else begin
      if (grant_wr || grant_rd) begin
        if (grant_wr == last_wr)
          burst_cnt <= (burst_cnt == BW'(BURST_MAX)) ? burst_cnt : burst_cnt + 1'b1;
        else
          burst_cnt <= BW'(1);
        last_wr <= grant_wr;
      end
      case (state)
        IDLE: begin
          wbeat <= '0;
          if (grant_wr)      state <= WR_DATA;
          else if (grant_rd) state <= RD_CMD;
        end
        WR_DATA: begin
          if (app_wdf_rdy) begin
            if (wbeat == LAST_BEAT) begin
              wbeat <= '0;
              state <= WR_CMD;
            end else begin
              wbeat <= wbeat + 3'd1;
            end
          end
        end
        WR_CMD:  if (app_rdy) state <= IDLE;
        default: if (app_rdy) state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rd_accept) tag_mem[tag_wp] <= rd_adx_in;
  end

  always_comb begin
    asm_next = asm_q;
    asm_next[rbeat*APP_DATA_W +: APP_DATA_W] = app_rd_data;
  end

  // Beats with no read in flight are dropped so a stray return can never fabricate a word
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_wp      <= '0;
      tag_rp      <= '0;
      outstanding <= '0;
      rbeat       <= '0;
      asm_q       <= '0;
      ret_valid   <= 1'b0;
      ret_data    <= '0;
      ret_adx     <= '0;
    end else begin
      ret_valid <= 1'b0;
      if (rd_accept) tag_wp <= tag_wp + 1'b1;
      if (ret_done)  tag_rp <= tag_rp + 1'b1;
      case ({rd_accept, ret_done})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (beat_ok) begin
        asm_q <= asm_next;
        if (rbeat == LAST_BEAT) begin
          rbeat     <= '0;
          ret_valid <= 1'b1;
          ret_data  <= asm_next;
          ret_adx   <= tag_mem[tag_rp];
        end else begin
          rbeat <= rbeat + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_cmd_dispatch_arb.sv
// Directed bench for ddr_cmd_dispatch_arb: vector table for write handshakes plus
// sequences for arbitration order, read limit, read reassembly and mid-write reset.
module tb_ddr_cmd_dispatch_arb;

  localparam int ADDR_W = 27;
  localparam int APP_W  = 64;
  localparam int USER_W = 128;
  localparam int MAXO   = 8;
  localparam int OW     = $clog2(MAXO) + 1;
  localparam logic [7:0] W_CH = 8'h57;
  localparam logic [7:0] R_CH = 8'h52;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic              has_wr, get_wr, has_rd_req, get_rd_req;
  logic [ADDR_W-1:0] wr_adx_in, rd_adx_in, app_addr, ret_adx;
  logic [USER_W-1:0] wr_data_in, ret_data;
  logic [2:0]        app_cmd;
  logic              app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [APP_W-1:0]  app_wdf_data, app_rd_data;
  logic              app_rd_data_valid, ret_valid;
  logic [OW-1:0]     outstanding;

  logic              m0_has_wr, m0_get_wr, m0_has_rd, m0_get_rd;
  logic [ADDR_W-1:0] m0_app_addr, m0_ret_adx;
  logic [2:0]        m0_app_cmd;
  logic              m0_app_en, m0_wren, m0_wend, m0_ret_valid;
  logic [APP_W-1:0]  m0_wdf_data;
  logic [USER_W-1:0] m0_ret_data;
  logic [OW-1:0]     m0_outstanding;

  ddr_cmd_dispatch_arb #(.ARB_MODE(2)) dut (
    .clk(clk), .resetn(resetn),
    .has_wr(has_wr), .wr_adx_in(wr_adx_in), .wr_data_in(wr_data_in), .get_wr(get_wr),
    .has_rd_req(has_rd_req), .rd_adx_in(rd_adx_in), .get_rd_req(get_rd_req),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .ret_data(ret_data), .ret_adx(ret_adx), .ret_valid(ret_valid), .outstanding(outstanding)
  );

  ddr_cmd_dispatch_arb #(.ARB_MODE(0)) dut_m0 (
    .clk(clk), .resetn(resetn),
    .has_wr(m0_has_wr), .wr_adx_in(27'h40), .wr_data_in({USER_W{1'b1}}), .get_wr(m0_get_wr),
    .has_rd_req(m0_has_rd), .rd_adx_in(27'h80), .get_rd_req(m0_get_rd),
    .app_addr(m0_app_addr), .app_cmd(m0_app_cmd), .app_en(m0_app_en), .app_rdy(1'b1),
    .app_wdf_data(m0_wdf_data), .app_wdf_wren(m0_wren), .app_wdf_end(m0_wend),
    .app_wdf_rdy(1'b1), .app_rd_data({APP_W{1'b0}}), .app_rd_data_valid(1'b0),
    .ret_data(m0_ret_data), .ret_adx(m0_ret_adx), .ret_valid(m0_ret_valid),
    .outstanding(m0_outstanding)
  );

  typedef struct {
    logic        req;
    logic        has_wr;
    logic        wdf_rdy;
    logic        app_rdy;
    logic        wren;
    logic        wend;
    logic [63:0] wdata;
    logic        en;
    logic [26:0] addr;
    logic        get;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   auto_src = 1'b0;
  int   wr_left = 0, rd_left = 0, wr_sent = 0, rd_sent = 0;
  int   m0_wr_left = 0, m0_rd_left = 0;
  logic [7:0] log2[$];
  logic [7:0] log0[$];

  localparam logic [26:0]  P0_ADX  = 27'h100;
  localparam logic [127:0] P0_DATA = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
  localparam logic [26:0]  P1_ADX  = 27'h200;
  localparam logic [127:0] P1_DATA = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB};
  localparam logic [127:0] P2_DATA = {64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};

  function automatic logic [63:0] lo_beat(input int k);
    return 64'hA0A0_0000_0000_0000 + 64'(k);
  endfunction

  function automatic logic [63:0] hi_beat(input int k);
    return 64'hB1B1_0000_0000_0000 + 64'(k);
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; in auto mode the request sources follow the pops each DUT makes
  task automatic step();
    @(posedge clk); #1;
    if (auto_src) begin
      has_wr     = wr_left > 0;
      wr_adx_in  = 27'h1000 + 27'(wr_sent);
      wr_data_in = {64'(wr_sent), 64'hC0DE};
      has_rd_req = rd_left > 0;
      rd_adx_in  = 27'(16 * (rd_sent + 1));
      m0_has_wr  = m0_wr_left > 0;
      m0_has_rd  = m0_rd_left > 0;
    end
    #1;
    if (auto_src) begin
      if (get_wr)     begin wr_left--; wr_sent++; log2.push_back(W_CH); end
      if (get_rd_req) begin rd_left--; rd_sent++; log2.push_back(R_CH); end
      if (m0_get_wr)  begin m0_wr_left--; log0.push_back(W_CH); end
      if (m0_get_rd)  begin m0_rd_left--; log0.push_back(R_CH); end
    end
  endtask

  task automatic add_vec(input logic req, input logic hw, input logic wrdy, input logic ardy,
                         input logic wren, input logic wend, input logic [63:0] wd,
                         input logic en, input logic [26:0] addr, input logic get);
    vec_t v;
    v.req = req; v.has_wr = hw; v.wdf_rdy = wrdy; v.app_rdy = ardy;
    v.wren = wren; v.wend = wend; v.wdata = wd; v.en = en; v.addr = addr; v.get = get;
    vq.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v);
    has_wr      = v.has_wr;
    wr_adx_in   = v.req ? P1_ADX : P0_ADX;
    wr_data_in  = v.req ? P1_DATA : P0_DATA;
    app_wdf_rdy = v.wdf_rdy;
    app_rdy     = v.app_rdy;
    has_rd_req  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    string exp2, exp0;
    has_wr = 0; has_rd_req = 0; wr_adx_in = '0; rd_adx_in = '0; wr_data_in = '0;
    app_rdy = 0; app_wdf_rdy = 0; app_rd_data = '0; app_rd_data_valid = 0;
    m0_has_wr = 0; m0_has_rd = 0;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_ctrl", {app_en, app_wdf_wren, app_wdf_end, get_wr, get_rd_req, ret_valid, app_cmd}, '0);
    check_output("reset_addr_data", {app_addr, app_wdf_data}, '0);
    check_output("reset_outstanding", outstanding, '0);
    #1 resetn = 1'b1;

    // Arbitration order: mode 2 bursts of 4, mode 0 writes first; read limit of 8
    app_rdy = 1; app_wdf_rdy = 1;
    wr_left = 10; rd_left = 10; m0_wr_left = 10; m0_rd_left = 10;
    auto_src = 1'b1;
    for (int c = 0; c < 400 && !(log2.size() >= 18 && log0.size() >= 18); c++) step();
    repeat (20) step();
    exp2 = "WWWWRRRRWWWWRRRRWW";
    exp0 = "WWWWWWWWWWRRRRRRRR";
    for (int i = 0; i < 18; i++) begin
      check_output($sformatf("order_mode2[%0d]", i), (i < log2.size()) ? log2[i] : 8'h2D, exp2[i]);
      check_output($sformatf("order_mode0[%0d]", i), (i < log0.size()) ? log0[i] : 8'h2D, exp0[i]);
    end
    check_output("mode2_issue_count", log2.size(), 18);
    check_output("mode0_issue_count", log0.size(), 18);
    check_output("mode2_outstanding_full", outstanding, 8);
    check_output("mode0_outstanding_full", m0_outstanding, 8);

    // Drain: each read returns lo then hi; stalled reads 9 and 10 issue as slots free up
    for (int k = 0; k < 10; k++) begin
      step();
      app_rd_data_valid = 1; app_rd_data = lo_beat(k);
      step();
      app_rd_data = hi_beat(k);
      step();
      app_rd_data_valid = 0;
      check_output($sformatf("ret_valid[%0d]", k), ret_valid, 1);
      check_output($sformatf("ret_data[%0d]", k), ret_data, {hi_beat(k), lo_beat(k)});
      check_output($sformatf("ret_adx[%0d]", k), ret_adx, 27'(16 * (k + 1)));
      step();
      check_output($sformatf("ret_strobe_drop[%0d]", k), ret_valid, 0);
    end
    repeat (3) step();
    check_output("drain_outstanding", outstanding, 0);
    check_output("reads_issued_total", rd_sent, 10);
    auto_src = 1'b0;
    has_wr = 0; has_rd_req = 0;

    // Orphan beats with nothing outstanding are ignored
    step();
    app_rd_data_valid = 1; app_rd_data = 64'hDEAD;
    step();
    app_rd_data = 64'hBEEF;
    step();
    app_rd_data_valid = 0;
    step();
    check_output("orphan_no_ret", ret_valid, 0);
    check_output("orphan_outstanding", outstanding, 0);
    check_output("ret_adx_hold", ret_adx, 27'h0A0);
    check_output("ret_data_hold", ret_data, {hi_beat(9), lo_beat(9)});

    // Write handshake table: single write, then wdf_rdy and app_rdy stalls
    add_vec(0, 1, 1, 0,  0, 0, 64'h0,                  0, 27'h0, 0);
    add_vec(0, 1, 1, 0,  1, 0, 64'h2222_2222_2222_2222, 0, 27'h0, 0);
    add_vec(0, 1, 1, 0,  1, 1, 64'h1111_1111_1111_1111, 0, 27'h0, 0);
    add_vec(0, 1, 1, 1,  0, 0, 64'h0,                  1, P0_ADX, 1);
    add_vec(1, 0, 0, 0,  0, 0, 64'h0,                  0, 27'h0, 0);
    add_vec(1, 1, 0, 0,  0, 0, 64'h0,                  0, 27'h0, 0);
    add_vec(1, 1, 1, 0,  1, 0, 64'hBBBB_BBBB_BBBB_BBBB, 0, 27'h0, 0);
    for (int i = 0; i < 3; i++)
      add_vec(1, 1, 0, 0, 1, 1, 64'hAAAA_AAAA_AAAA_AAAA, 0, 27'h0, 0);
    add_vec(1, 1, 1, 0,  1, 1, 64'hAAAA_AAAA_AAAA_AAAA, 0, 27'h0, 0);
    for (int i = 0; i < 5; i++)
      add_vec(1, 1, 0, 0, 0, 0, 64'h0, 1, P1_ADX, 0);
    add_vec(1, 1, 0, 1,  0, 0, 64'h0,                  1, P1_ADX, 1);
    add_vec(1, 0, 0, 0,  0, 0, 64'h0,                  0, 27'h0, 0);
    for (int i = 0; i < vq.size(); i++) begin
      step();
      apply_stimulus(vq[i]);
      #1;
      check_output($sformatf("wr_vec%0d", i),
                   {app_wdf_wren, app_wdf_end, app_wdf_data, app_en, app_cmd, app_addr, get_wr, get_rd_req},
                   {vq[i].wren, vq[i].wend, vq[i].wdata, vq[i].en, 3'b000, vq[i].addr, vq[i].get, 1'b0});
    end

    // Async reset mid-write, then the same request restarts from beat 0
    step();
    has_wr = 1; wr_adx_in = 27'h300; wr_data_in = P2_DATA; app_wdf_rdy = 1; app_rdy = 0;
    step();
    check_output("pre_rst_beat0", {app_wdf_wren, app_wdf_data}, {1'b1, 64'h4444_4444_4444_4444});
    step();
    resetn = 1'b0;
    #1;
    check_output("rst_async_ctrl", {app_en, app_wdf_wren, app_wdf_end, get_wr, get_rd_req, ret_valid, app_cmd}, '0);
    check_output("rst_async_bus", {app_addr, app_wdf_data}, '0);
    check_output("rst_async_ret", {ret_data, ret_adx}, '0);
    step();
    step();
    resetn = 1'b1;
    step();
    check_output("restart_beat0", {app_wdf_wren, app_wdf_end, app_wdf_data}, {2'b10, 64'h4444_4444_4444_4444});
    step();
    check_output("restart_beat1", {app_wdf_wren, app_wdf_end, app_wdf_data}, {2'b11, 64'h3333_3333_3333_3333});
    step();
    app_rdy = 1;
    #1;
    check_output("restart_cmd", {app_en, app_cmd, app_addr, get_wr}, {1'b1, 3'b000, 27'h300, 1'b1});
    step();
    has_wr = 0; app_rdy = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_dispatch_arb.md
Name: ddr_cmd_dispatch_arb

Overview:
Parametrised successor to the write/read FIFO-to-controller dispatch stage. It drains queued write and read requests from the request FIFOs and issues them to the DDR2 controller application interface. Arbitration mode is selectable, wide user words are split into multi-beat writes, and outstanding reads are tracked with a bounded count. Returned read beats are reassembled into user-width words, each tagged with its original address. It sits between the request FIFOs and the memory controller in the soc_clk domain.

Parameters:
ADDR_W, 27, request/app address width
APP_DATA_W, 64, controller data-bus width per beat
USER_DATA_W, 128, request data width; integer multiple of APP_DATA_W; BEATS = USER_DATA_W/APP_DATA_W (1..8)
ARB_MODE, 2, 0 = write priority, 1 = read priority, 2 = round-robin with burst limit
BURST_MAX, 4, consecutive same-type commands allowed in mode 2 while the other type is pending (>=1)
MAX_OUTSTANDING, 8, maximum reads issued but not yet returned (power of 2, >=2)

Ports:
clk  in  1  soc clock
resetn  in  1  asynchronous active-low reset
has_wr  in  1  write request (address+data) available
wr_adx_in  in  ADDR_W  write address
wr_data_in  in  USER_DATA_W  write data
get_wr  out  1  one-cycle pop of write request
has_rd_req  in  1  read request available
rd_adx_in  in  ADDR_W  read address
get_rd_req  out  1  one-cycle pop of read request
app_addr  out  ADDR_W  controller address
app_cmd  out  3  000 = write, 001 = read
app_en  out  1  command valid
app_rdy  in  1  command accepted when app_en&app_rdy
app_wdf_data  out  APP_DATA_W  write beat
app_wdf_wren  out  1  write beat valid
app_wdf_end  out  1  last beat of a write
app_wdf_rdy  in  1  beat accepted when wren&wdf_rdy
app_rd_data  in  APP_DATA_W  read beat
app_rd_data_valid  in  1  read beat valid
ret_data  out  USER_DATA_W  reassembled read word
ret_adx  out  ADDR_W  address of ret_data
ret_valid  out  1  one-cycle strobe; no backpressure
outstanding  out  $clog2(MAX_OUTSTANDING)+1  reads in flight

Behaviour:
- Reset: all outputs 0, including app_cmd=000, state IDLE, beat counters 0, burst counter 0, tag FIFO empty, last-served type = read. Async assertion aborts any in-progress transfer; no partial beats are retained.
- States: IDLE, WR_DATA, WR_CMD, RD_CMD.
- IDLE arbitration:
  - Candidates: write if has_wr; read if has_rd_req && outstanding<MAX_OUTSTANDING.
  - Mode 0: write wins if eligible.
  - Mode 1: read wins if eligible.
  - Mode 2: alternate from last-served type. The same type may repeat while the other is not eligible. It may also repeat while burst_cnt<BURST_MAX. burst_cnt resets to 1 on a type switch.
  - One cycle of arbitration latency in IDLE.
- WR_DATA: beat i drives wr_data_in[i*APP_DATA_W +: APP_DATA_W], low beat first, with app_wdf_wren=1. The index advances only on wren&wdf_rdy. app_wdf_end=1 on beat BEATS-1. After the last beat is accepted, go to WR_CMD.
- WR_CMD: app_en=1, app_cmd=000, app_addr=wr_adx_in, all held until app_rdy. On accept: get_wr=1 for one cycle, go to IDLE.
- RD_CMD: app_en=1, app_cmd=001, app_addr=rd_adx_in, held until app_rdy. On accept: get_rd_req=1 for one cycle, rd_adx_in pushed into tag FIFO (depth MAX_OUTSTANDING), outstanding+1, go to IDLE.
- Inputs must stay stable while has_* is high until the corresponding get_*; the block does not register request payloads.
- Read return:
  - Each app_rd_data_valid beat is written into slot rbeat of the assembly register, low first.
  - On beat BEATS-1, the next cycle drives ret_valid=1, ret_data=assembled word, ret_adx=tag FIFO head. The FIFO pops and outstanding-1.
  - Return path runs concurrently with any state.
  - Read accept and return completion in the same cycle: outstanding unchanged, push and pop both performed.
- Beats arriving with tag FIFO empty: protocol error; ignored, no ret_valid.
- outstanding==MAX_OUTSTANDING: reads ineligible; writes still proceed.
- ret_data/ret_adx hold their last value after ret_valid drops.
- BEATS=1: WR_DATA is a single beat with app_wdf_end=1.

Test Plan:
- Single write, adx=0x0000100, data=128'h1111…_2222…, wdf_rdy=1 -> beats 64'h2222…, then 64'h1111… with end=1; then app_en cmd=000 addr=0x100; get_wr pulses once.
- wdf_rdy low for 3 cycles mid-write, app_rdy low for 5 cycles -> beat and command held stable; no duplicate beats; single get_wr.
- Mode 2, BURST_MAX=4, 10 writes and 10 reads pending -> issue order W,W,W,W,R,R,R,R,W…; mode 0 -> all 10 writes first.
- 9 reads issued, no return data, MAX_OUTSTANDING=8 -> 8 accepted, outstanding=8, 9th read stalls; a pending write still issues.
- Reads to 0x10,0x20 returning beats A0,A1,B0,B1 -> ret_valid twice with {A1,A0}/0x10, then {B1,B0}/0x20; outstanding returns to 0.
- resetn pulsed low during WR_DATA after beat 0 -> all outputs 0 immediately; after release, the same request restarts at beat 0.
